aes_inv_key_sched: RTL
======================

Name: aes_inv_key_sched

Overview:
- Iterative inverse AES-128 key schedule for the decryption datapath.
- Loaded with the round-10 key, it walks the schedule backwards and emits round keys 10, 9, …, 0, one per accepted valid/ready transfer.
- Feeds AddRoundKey of the inverse cipher and avoids storing all 11 round keys.
- Reuses the existing forward G-function (RotWord, SubWord, Rcon XOR) in reverse order.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; any other value is a compile-time error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  load request; honoured only when busy=0.
- key_in  in  128  round-10 key (or cipher key if KEY_PRECOMP_EN); byte 0 = key_in[127:120]; word w0 = bytes 0..3.
- rk_ready  in  1  downstream accepts rk_out this cycle.
- rk_valid  out  1  rk_out/rk_num valid.
- rk_out  out  128  current round key, same byte order as key_in.
- rk_num  out  4  round index of rk_out, 10 down to 0.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after round 0 is accepted.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE; rk_valid=0, rk_out=0, rk_num=0, busy=0, done=0. Reset mid-sequence aborts immediately; no partial output follows.
- States: IDLE, (PRECOMP if enabled), EMIT.
- IDLE:
  - start=1 → register key_in, rk_num=10, busy=1, state=EMIT.
  - rk_valid=1 from the next cycle, so latency start→first valid is 1 cycle.
  - start while busy=1 is ignored.
- EMIT:
  - rk_valid=1. rk_out and rk_num hold stable while rk_ready=0.
  - On rk_valid&rk_ready with rk_num>0: register the previous key and decrement rk_num. rk_valid stays 1, giving back-to-back throughput of one key per cycle.
  - On rk_valid&rk_ready with rk_num=0: rk_valid=0, busy=0, done=1 for one cycle, state=IDLE. rk_out keeps its last value.
- Inverse step, current key (w0,w1,w2,w3), round r:
  - p3=w3^w2; p2=w2^w1; p1=w1^w0.
  - p0=w0^G(p3,r), where G = RotWord, SubWord, byte0 ^ Rcon[r].
  - Rcon[1..10]=01,02,04,08,10,20,40,80,1B,36.
  - Purely combinational from the registered key; one step per cycle.
- start asserted the same cycle done pulses: accepted, because state is already IDLE at that edge check. The new sequence begins the following cycle.

Optional Feature:
- Macro: AES_KEY_PRECOMP_EN.
- Defined:
  - key_in is the cipher key (round 0).
  - start → PRECOMP: 10 cycles of forward expansion in place, using w0'=w0^G(w3,r), with r=1..10 counted by a 4-bit counter.
  - Then EMIT as above. Latency start→first valid = 11 cycles; busy=1 throughout PRECOMP, rk_valid=0.
- Undefined: PRECOMP state, forward datapath and counter are absent; key_in must be the round-10 key.

Decomposition:
- Package aes_pkg:
  - byte/word typedefs (logic [7:0], 4-byte word);
  - Rcon constant array indexed 1..10;
  - state enum {IDLE, PRECOMP, EMIT};
  - NR constant.
- One natural sub-module: aes_inv_key_step. Combinational; takes current key and round number, returns previous key. It instantiates the existing G-function block with Rnum=r.
- The forward step under the macro reuses the same G instance through a mux on its input word.

Test Plan:
- FIPS-197 A.1: load d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_ready=1.
  - Cycle+1: rk_num=10, rk_out=d014f9a8…b6630ca6.
  - Next: rk_num=9, rk_out=ac7766f319fadc2128d12941575c006e.
  - Last: rk_num=0, rk_out=2b7e151628aed2a6abf7158809cf4f3c; done pulses one cycle after it.
- Backpressure: same load, rk_ready toggled randomly.
  - Every key is held stable until accepted; exactly 11 transfers in order 10..0; no skips or duplicates.
- Reset mid-sequence: rst_n=0 at rk_num=5.
  - Next cycle rk_valid=0, busy=0, rk_num=0.
  - A fresh start then reproduces the full sequence from 10.
- Start while busy: pulse start with a different key_in at rk_num=7.
  - Ignored; remaining keys match the original schedule.
- Start coincident with done: a new key is loaded that cycle.
  - rk_valid=1, rk_num=10 with the new key on the following cycle.
- With AES_KEY_PRECOMP_EN: load 2b7e151628aed2a6abf7158809cf4f3c.
  - rk_valid stays 0 for 10 cycles.
  - First output is rk_num=10, d014f9a8c9ee2589e13f0cc8b6630ca6; rest as in the FIPS-197 A.1 scenario.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types, round constants and the S-box lookup for the key schedule.
// Pure declarations; no state, no handshake.
package aes_pkg;

    typedef logic [7:0]       byte_t;
    typedef logic [3:0][7:0]  word_t;   // [3] is byte 0 (MSB)
    typedef logic [127:0]     key_t;    // w0 = [127:96], byte 0 = [127:120]

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECOMP = 2'd1,
        EMIT    = 2'd2
    } state_e;

    localparam int NR = 10;

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

    // Round 0 and 11..15 never reach AddRoundKey; they yield a zero constant.
    function automatic byte_t rcon(input logic [3:0] r);
        byte_t v;
        v = 8'h00;
        if (r >= 4'd1 && r <= 4'd10) v = RCON[r];
        return v;
    endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// Handshake/bus bundle between the key schedule and the inverse cipher.
// Round keys move on rk_valid & rk_ready; start is a level sampled while idle.
interface aes_inv_key_sched_if;
    import aes_pkg::*;

    logic       start;
    key_t       key_in;
    logic       rk_ready;
    logic       rk_valid;
    key_t       rk_out;
    logic [3:0] rk_num;
    logic       busy;
    logic       done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, rk_out, rk_num, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, rk_out, rk_num, busy, done
    );

endinterface

// File: rtl/aes_g_func.sv
// AES key-expansion G function: RotWord, SubWord, then Rcon[rnum] into byte 0.
// Combinational, zero latency; no handshake.
module aes_g_func
    import aes_pkg::*;
(
    input  word_t      w_in,
    input  logic [3:0] rnum,
    output word_t      w_out
);

    word_t rot;

    assign rot = {w_in[2], w_in[1], w_in[0], w_in[3]};

    assign w_out[3] = sbox(rot[3]) ^ rcon(rnum);
    assign w_out[2] = sbox(rot[2]);
    assign w_out[1] = sbox(rot[1]);
    assign w_out[0] = sbox(rot[0]);

endmodule

// File: rtl/aes_inv_key_step.sv
// One backward key-schedule step (round r key -> round r-1 key); optional forward step shares the G block.
// Combinational, zero latency; no handshake.
module aes_inv_key_step
    import aes_pkg::*;
(
    input  key_t       cur_key,
    input  logic [3:0] rnd,
`ifdef AES_KEY_PRECOMP_EN
    input  logic       fwd_sel,
    output key_t       nxt_key,
`endif
    output key_t       prv_key
);

    word_t w0, w1, w2, w3;
    word_t p1, p2, p3;
    word_t g_in, g_out;

    assign w0 = cur_key[127:96];
    assign w1 = cur_key[95:64];
    assign w2 = cur_key[63:32];
    assign w3 = cur_key[31:0];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

`ifdef AES_KEY_PRECOMP_EN
    // Forward expansion feeds w3 into G; backward feeds the recovered p3.
    assign g_in = fwd_sel ? w3 : p3;
`else
    assign g_in = p3;
`endif

    aes_g_func u_g (
        .w_in  (g_in),
        .rnum  (rnd),
        .w_out (g_out)
    );

    assign prv_key = {w0 ^ g_out, p1, p2, p3};

`ifdef AES_KEY_PRECOMP_EN
    word_t n0, n1, n2, n3;
    assign n0 = w0 ^ g_out;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nxt_key = {n0, n1, n2, n3};
`endif

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative inverse AES-128 key schedule emitting round keys 10..0; AES_KEY_PRECOMP_EN loads the cipher key instead.
// Latency start->first rk_valid: 1 cycle (11 with precompute); rk_out/rk_num hold while rk_ready=0, one key/cycle otherwise.
module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input logic                      clk,
    input logic                      rst_n,
    aes_inv_key_sched_if.slave       kif
);
    import aes_pkg::*;

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_inv_key_sched supports only NR=10 (AES-128)");
        end
    endgenerate

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_e     state_q, state_d;
    key_t       key_q, key_d;
    logic [3:0] rk_num_q, rk_num_d;
    logic       done_q, done_d;
    key_t       prv_key;
    logic [3:0] step_rnd;

`ifdef AES_KEY_PRECOMP_EN
    logic [3:0] cnt_q, cnt_d;
    logic       fwd_sel;
    key_t       nxt_key;

    assign fwd_sel  = (state_q == PRECOMP);
    assign step_rnd = fwd_sel ? cnt_q : rk_num_q;
`else
    assign step_rnd = rk_num_q;
`endif

    aes_inv_key_step u_step (
        .cur_key (key_q),
        .rnd     (step_rnd),
`ifdef AES_KEY_PRECOMP_EN
        .fwd_sel (fwd_sel),
        .nxt_key (nxt_key),
`endif
        .prv_key (prv_key)
    );

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        rk_num_d = rk_num_q;
        done_d   = 1'b0;
`ifdef AES_KEY_PRECOMP_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (kif.start) begin
                    key_d = kif.key_in;
`ifdef AES_KEY_PRECOMP_EN
                    state_d = PRECOMP;
                    cnt_d   = 4'd1;
`else
                    state_d  = EMIT;
                    rk_num_d = LAST_RND;
`endif
                end
            end
`ifdef AES_KEY_PRECOMP_EN
            PRECOMP: begin
                key_d = nxt_key;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_RND) begin
                    state_d  = EMIT;
                    rk_num_d = LAST_RND;
                end
            end
`endif
            EMIT: begin
                if (kif.rk_ready) begin
                    if (rk_num_q != 4'd0) begin
                        key_d    = prv_key;
                        rk_num_d = rk_num_q - 4'd1;
                    end else begin
                        // rk_out keeps round 0 so a late reader still sees it.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            key_q    <= '0;
            rk_num_q <= 4'd0;
            done_q   <= 1'b0;
`ifdef AES_KEY_PRECOMP_EN
            cnt_q    <= 4'd0;
`endif
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            rk_num_q <= rk_num_d;
            done_q   <= done_d;
`ifdef AES_KEY_PRECOMP_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign kif.rk_valid = (state_q == EMIT);
    assign kif.busy     = (state_q != IDLE);
    assign kif.rk_out   = key_q;
    assign kif.rk_num   = rk_num_q;
    assign kif.done     = done_q;

endmodule
